// File: rtl/imu_read_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : imu_read_sequencer_if
// Purpose  : Byte-level handshake between the IMU read sequencer and spi_master.
// Revision : 1.0
// ============================================================================
interface imu_read_sequencer_if;
  logic       spi_start;
  logic [7:0] spi_data_in;
  logic       spi_busy;
  logic       spi_new_data;
  logic [7:0] spi_data_out;

  modport master (
    output spi_start,
    output spi_data_in,
    input  spi_busy,
    input  spi_new_data,
    input  spi_data_out
  );

  modport slave (
    input  spi_start,
    input  spi_data_in,
    output spi_busy,
    output spi_new_data,
    output spi_data_out
  );
endinterface
`default_nettype wire

// File: rtl/imu_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : imu_read_sequencer
// Purpose  : Burst-reads NUM_BYTES IMU registers per trigger and publishes them
//            as one atomic frame. Optional per-byte timeout: IMU_SEQ_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module imu_read_sequencer #(
  parameter logic [6:0] START_REG = 7'h3B,
  parameter int         NUM_BYTES = 14,
  parameter int         SS_SETUP  = 4,
  parameter int         SS_HOLD   = 4,
  parameter int         TIMEOUT   = 4096
) (
  input  wire                    clk,
  input  wire                    rst,
  input  wire                    trig,
  imu_read_sequencer_if.master   spi,
  output logic                   imu_ss,
  output logic [NUM_BYTES*8-1:0] frame,
  output logic                   frame_valid,
  output logic                   busy,
  output logic                   missed,
  output logic                   err
);

  localparam int         IW         = $clog2(NUM_BYTES + 1);
  localparam int         CMAX       = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
  localparam int         CW         = $clog2(CMAX + 1);
  localparam logic [7:0] ADDR_BYTE  = {1'b1, START_REG};
  localparam logic [7:0] DUMMY_BYTE = 8'hFF;

  if (NUM_BYTES < 1 || NUM_BYTES > 32 || SS_SETUP < 1 || SS_HOLD < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("imu_read_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ADDR   = 3'd2,
    S_WAIT_A = 3'd3,
    S_DATA   = 3'd4,
    S_WAIT_D = 3'd5,
    S_HOLD   = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [IW-1:0]          idx, idx_n;
  logic                   aborted, aborted_n;
  logic [NUM_BYTES*8-1:0] shadow;
  logic                   ss_n, start_n, fv_n;
  logic [7:0]             din_n;
  logic                   store, load_frame, timeout_hit;

`ifdef IMU_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          err_r;

  // Saturating wait counter, restarted with every byte transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt  <= '0;
      err_r <= 1'b0;
    end else begin
      err_r <= timeout_hit;
      if (start_n)
        tcnt <= '0;
      else if ((state == S_WAIT_A || state == S_WAIT_D) && tcnt != TW'(TIMEOUT))
        tcnt <= tcnt + TW'(1);
    end
  end

  assign timeout_hit = (state == S_WAIT_A || state == S_WAIT_D) && !spi.spi_new_data
                       && (tcnt == TW'(TIMEOUT));
  assign err = err_r;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    aborted_n  = aborted;
    ss_n       = imu_ss;
    start_n    = 1'b0;
    din_n      = spi.spi_data_in;
    fv_n       = 1'b0;
    store      = 1'b0;
    load_frame = 1'b0;
    case (state)
      S_IDLE: begin
        if (trig) begin
          state_n   = S_SETUP;
          ss_n      = 1'b0;
          cnt_n     = '0;
          idx_n     = '0;
          aborted_n = 1'b0;
        end
      end
      S_SETUP: begin
        if (cnt == CW'(SS_SETUP - 1)) state_n = S_ADDR;
        else                          cnt_n   = cnt + CW'(1);
      end
      S_ADDR: begin
        din_n = ADDR_BYTE;
        if (!spi.spi_busy) begin
          start_n = 1'b1;
          state_n = S_WAIT_A;
        end
      end
      S_WAIT_A: begin
        if (spi.spi_new_data) begin
          state_n = S_DATA;
        end else if (timeout_hit) begin
          state_n   = S_HOLD;
          ss_n      = 1'b1;
          cnt_n     = '0;
          aborted_n = 1'b1;
        end
      end
      S_DATA: begin
        din_n = DUMMY_BYTE;
        if (!spi.spi_busy) begin
          start_n = 1'b1;
          state_n = S_WAIT_D;
        end
      end
      S_WAIT_D: begin
        if (spi.spi_new_data) begin
          store = 1'b1;
          idx_n = idx + IW'(1);
          if (idx == IW'(NUM_BYTES - 1)) begin
            state_n = S_HOLD;
            ss_n    = 1'b1;
            cnt_n   = '0;
          end else begin
            state_n = S_DATA;
          end
        end else if (timeout_hit) begin
          state_n   = S_HOLD;
          ss_n      = 1'b1;
          cnt_n     = '0;
          aborted_n = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt == CW'(SS_HOLD - 1)) begin
          // An aborted burst returns straight to idle so frame is never touched.
          if (aborted) begin
            state_n = S_IDLE;
          end else begin
            state_n    = S_DONE;
            load_frame = 1'b1;
            fv_n       = 1'b1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      idx             <= '0;
      aborted         <= 1'b0;
      imu_ss          <= 1'b1;
      spi.spi_start   <= 1'b0;
      spi.spi_data_in <= 8'hFF;
      frame_valid     <= 1'b0;
      busy            <= 1'b0;
      missed          <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      idx             <= idx_n;
      aborted         <= aborted_n;
      imu_ss          <= ss_n;
      spi.spi_start   <= start_n;
      spi.spi_data_in <= din_n;
      frame_valid     <= fv_n;
      busy            <= (state_n != S_IDLE);
      missed          <= trig && (state != S_IDLE);
    end
  end

  // First received byte lands in the most significant byte of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      frame  <= '0;
    end else begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (store && idx == IW'(NUM_BYTES - 1 - i))
          shadow[i*8 +: 8] <= spi.spi_data_out;
      end
      if (load_frame)
        frame <= shadow;
    end
  end

endmodule
`default_nettype wire
